memory_address_unit: RTL and testbench
======================================

MEMORY_ADDRESS_UNIT -- requirements
Module: memory_address_unit

Interface
REQ-001 Parameter ADDR_W, default 8, is the width of the held address; legal range BUS_W <= ADDR_W <= 2*BUS_W.
REQ-002 Parameter BUS_W, default 4, is the width of the data bus the address is loaded from.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_lo  input  1  load low address part from bus (or the full address when ADDR_W == BUS_W).
REQ-006 load_hi  input  1  commit high address part from bus (split mode only).
REQ-007 inc  input  1  increment address by 1.
REQ-008 dec  input  1  decrement address by 1.
REQ-009 manual_mode  input  1  front-panel override; address driven from switches.
REQ-010 manual_switches  input  ADDR_W  front-panel address.
REQ-011 bus  input  BUS_W  CPU data bus.
REQ-012 address  output  ADDR_W  effective memory address.
REQ-013 wrap  output  1  one-cycle pulse: last inc/dec wrapped around.
REQ-014 half_pending  output  1  high while the low part is staged and the high part is awaited.

Function
REQ-015 Internal state: cont_addr[ADDR_W], staged_lo[BUS_W], FSM state in {IDLE, HALF}, wrap register.
REQ-016 address SHALL equal manual_switches when manual_mode=1 and cont_addr otherwise (combinational mux, zero latency).
REQ-017 While manual_mode=1: cont_addr, staged_lo and wrap hold, wrap drives 0, all control inputs are ignored, FSM forced to IDLE on the next edge.
REQ-018 Priority when manual_mode=0: load_hi (HALF only) > load_lo > inc/dec; at most one operation per cycle.
REQ-019 ADDR_W == BUS_W: load_lo writes bus into cont_addr on the edge; load_hi is ignored; FSM stays IDLE.
REQ-020 ADDR_W > BUS_W, IDLE + load_lo: staged_lo <= bus, FSM -> HALF, cont_addr unchanged.
REQ-021 HALF + load_hi: cont_addr <= {bus[ADDR_W-BUS_W-1:0], staged_lo}, FSM -> IDLE; upper unused bus bits are ignored.
REQ-022 HALF + load_lo (without load_hi): staged_lo overwritten with bus, FSM stays HALF.
REQ-023 IDLE + load_hi: ignored, no state change.
REQ-024 HALF + inc or dec (no load): the inc/dec is applied to cont_addr and FSM stays HALF.
REQ-025 inc=1 and dec=1 together: no change to cont_addr, wrap=0.
REQ-026 inc SHALL be modulo 2^ADDR_W; all-ones -> 0 sets wrap=1 for exactly the following cycle.
REQ-027 dec SHALL be modulo 2^ADDR_W; 0 -> all-ones sets wrap=1 for exactly the following cycle.
REQ-028 wrap is registered and otherwise 0; every non-wrapping edge clears it.
REQ-029 half_pending = (FSM == HALF), registered-state decode, no combinational path from inputs.

Reset
REQ-030 rst=1 SHALL immediately force cont_addr=0, staged_lo=0, FSM=IDLE, wrap=0, half_pending=0, independent of clk.
REQ-031 Reset asserted while HALF SHALL discard the staged low part; a later load_hi without a new load_lo is ignored.
REQ-032 address during reset follows REQ-016 (switches if manual_mode=1, else 0).

Verification (ADDR_W=8, BUS_W=4 unless stated)
REQ-033 Reset, then load_lo with bus=0xA, next cycle load_hi with bus=0x3 -> half_pending 1 then 0, address=0x3A.
REQ-034 cont_addr=0xFF, inc for one cycle -> address=0x00 and wrap=1 for exactly one cycle; dec from 0x00 -> 0xFF, wrap=1 once.
REQ-035 load_lo bus=0x5, then manual_mode=1 with switches=0xC4 -> address=0xC4 immediately, half_pending=0 after one edge; manual_mode=0 -> address back to the prior cont_addr; load_hi ignored.
REQ-036 Asynchronous rst pulse mid-cycle while HALF with cont_addr=0x7E -> address=0x00, half_pending=0 before the next edge.
REQ-037 Simultaneous load_lo and inc in IDLE (bus=0x2, cont_addr=0x10) -> staged_lo=0x2, cont_addr stays 0x10; inc+dec together -> cont_addr unchanged.
REQ-038 ADDR_W=BUS_W=4: load_lo bus=0x9 -> address=0x9 after one edge, half_pending never asserts, load_hi has no effect.

Source files
------------

// File: rtl/memory_address_unit.sv
// Memory address register loaded from a narrow CPU bus (optionally in two halves),
// with inc/dec, wrap pulse and a front-panel manual override mux.
module memory_address_unit #(
   parameter int ADDR_W = 8,
   parameter int BUS_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_lo,
   input  logic              load_hi,
   input  logic              inc,
   input  logic              dec,
   input  logic              manual_mode,
   input  logic [ADDR_W-1:0] manual_switches,
   input  logic [BUS_W-1:0]  bus,
   output logic [ADDR_W-1:0] address,
   output logic              wrap,
   output logic              half_pending
);

   localparam bit SPLIT = (ADDR_W > BUS_W);

   typedef enum logic {IDLE, HALF} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cont_addr;
   logic [BUS_W-1:0]  staged_lo;
   logic              wrap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cont_addr <= '0;
         staged_lo <= '0;
         wrap_q    <= 1'b0;
      end else if (manual_mode) begin
         state  <= IDLE;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (SPLIT && state == HALF && load_hi) begin
            // Truncating {bus, staged_lo} keeps only the bus bits that fit above the low part.
            cont_addr <= ADDR_W'({bus, staged_lo});
            state     <= IDLE;
         end else if (load_lo) begin
            if (SPLIT) begin
               staged_lo <= bus;
               state     <= HALF;
            end else begin
               cont_addr <= ADDR_W'(bus);
            end
         end else if (inc && !dec) begin
            cont_addr <= cont_addr + 1'b1;
            wrap_q    <= (cont_addr == '1);
         end else if (dec && !inc) begin
            cont_addr <= cont_addr - 1'b1;
            wrap_q    <= (cont_addr == '0);
         end
      end
   end

   always_comb begin
      address      = manual_mode ? manual_switches : cont_addr;
      wrap         = wrap_q && !manual_mode;
      half_pending = (state == HALF);
   end

endmodule

// File: tb/tb_memory_address_unit.sv
// Directed bench: split 8/4 instance driven from a vector table plus hand sequences,
// and a 4/4 instance exercising the non-split path.
module tb_memory_address_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_lo, load_hi, inc, dec, manual_mode;
   logic [7:0] manual_switches;
   logic [3:0] bus;
   logic [7:0] address;
   logic       wrap, half_pending;

   logic       s_load_lo, s_load_hi, s_inc, s_dec, s_manual_mode;
   logic [3:0] s_manual_switches, s_bus, s_address;
   logic       s_wrap, s_half_pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_address_unit #(.ADDR_W(8), .BUS_W(4)) dut (
      .clk(clk), .rst(rst), .load_lo(load_lo), .load_hi(load_hi), .inc(inc), .dec(dec),
      .manual_mode(manual_mode), .manual_switches(manual_switches), .bus(bus),
      .address(address), .wrap(wrap), .half_pending(half_pending)
   );

   memory_address_unit #(.ADDR_W(4), .BUS_W(4)) dut_s (
      .clk(clk), .rst(rst), .load_lo(s_load_lo), .load_hi(s_load_hi), .inc(s_inc), .dec(s_dec),
      .manual_mode(s_manual_mode), .manual_switches(s_manual_switches), .bus(s_bus),
      .address(s_address), .wrap(s_wrap), .half_pending(s_half_pending)
   );

   typedef struct {
      logic       ll, lh, inc, dec, man;
      logic [7:0] sw;
      logic [3:0] bus;
      logic [7:0] e_addr;
      logic       e_wrap, e_half;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ll, input logic lh, input logic i, input logic d,
                        input logic [3:0] b);
      @(negedge clk);
      load_lo = ll; load_hi = lh; inc = i; dec = d; bus = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      {load_lo, load_hi, inc, dec, manual_mode} = '0;
      manual_switches = '0; bus = '0;
      {s_load_lo, s_load_hi, s_inc, s_dec, s_manual_mode} = '0;
      s_manual_switches = '0; s_bus = '0;

      //          ll lh in de mn sw     bus    addr   wr hf
      vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 4'hA, 8'h00, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'h3, 8'h3A, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'h5, 8'h3A, 0, 0});
      vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 4'h0, 8'h3B, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 8'h00, 4'h0, 8'h3A, 0, 0});
      vecs.push_back('{0, 0, 1, 1, 0, 8'h00, 4'h0, 8'h3A, 0, 0});
      vecs.push_back('{1, 0, 1, 0, 0, 8'h00, 4'h2, 8'h3A, 0, 1});
      vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 4'h0, 8'h3B, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'h1, 8'h12, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 4'hF, 8'h12, 0, 1});
      vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 4'hE, 8'h12, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'hF, 8'hFE, 0, 0});
      vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 4'h0, 8'hFF, 0, 0});
      vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 4'h0, 8'h00, 1, 0});
      vecs.push_back('{0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 8'h00, 4'h0, 8'hFF, 1, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 8'h00, 4'h0, 8'hFE, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 4'h5, 8'hFE, 0, 1});
      vecs.push_back('{0, 1, 1, 0, 1, 8'hC4, 4'h7, 8'hC4, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'hC4, 4'h7, 8'hFE, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 4'h0, 8'hFE, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'h1, 8'h10, 0, 0});
      vecs.push_back('{1, 0, 1, 0, 0, 8'h00, 4'h2, 8'h10, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 4'h0, 8'h02, 0, 0});

      #2;
      check("reset address", address, 8'h00);
      check("reset half", half_pending, 1'b0);
      check("reset wrap", wrap, 1'b0);
      check("reset s_address", s_address, 4'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int unsigned i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         load_lo = vecs[i].ll; load_hi = vecs[i].lh; inc = vecs[i].inc; dec = vecs[i].dec;
         manual_mode = vecs[i].man; manual_switches = vecs[i].sw; bus = vecs[i].bus;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d address", i), address, vecs[i].e_addr);
         check($sformatf("vec%0d wrap", i), wrap, vecs[i].e_wrap);
         check($sformatf("vec%0d half", i), half_pending, vecs[i].e_half);
      end
      @(negedge clk);
      {load_lo, load_hi, inc, dec, manual_mode} = '0;

      // Manual override is combinational; FSM drops to IDLE only on the next edge.
      drive(1, 0, 0, 0, 4'h6);
      @(negedge clk);
      load_lo = 0;
      manual_mode = 1; manual_switches = 8'h5A;
      #1;
      check("manual addr immediate", address, 8'h5A);
      check("manual half before edge", half_pending, 1'b1);
      @(posedge clk);
      #1;
      check("manual half after edge", half_pending, 1'b0);
      @(negedge clk);
      manual_mode = 0;
      #1;
      check("manual release addr", address, 8'h02);

      // Asynchronous reset mid-cycle while HALF discards the staged part.
      drive(1, 0, 0, 0, 4'hE);
      drive(0, 1, 0, 0, 4'h7);
      check("pre-reset addr", address, 8'h7E);
      drive(1, 0, 0, 0, 4'h3);
      check("pre-reset half", half_pending, 1'b1);
      @(negedge clk);
      load_lo = 0;
      #1 rst = 1'b1;
      #1;
      check("async rst addr", address, 8'h00);
      check("async rst half", half_pending, 1'b0);
      manual_mode = 1; manual_switches = 8'h99;
      #1;
      check("rst manual addr", address, 8'h99);
      manual_mode = 0;
      rst = 1'b0;
      drive(0, 1, 0, 0, 4'h9);
      check("post-rst load_hi addr", address, 8'h00);
      check("post-rst load_hi half", half_pending, 1'b0);

      // Non-split instance: load_lo loads the whole address.
      @(negedge clk);
      s_load_lo = 1; s_bus = 4'h9;
      @(posedge clk); #1;
      check("s load_lo addr", s_address, 4'h9);
      check("s load_lo half", s_half_pending, 1'b0);
      @(negedge clk);
      s_load_lo = 0; s_load_hi = 1; s_bus = 4'h3;
      @(posedge clk); #1;
      check("s load_hi addr", s_address, 4'h9);
      check("s load_hi half", s_half_pending, 1'b0);
      @(negedge clk);
      s_load_hi = 0; s_load_lo = 1; s_bus = 4'hF;
      @(posedge clk); #1;
      @(negedge clk);
      s_load_lo = 0; s_inc = 1;
      @(posedge clk); #1;
      check("s wrap addr", s_address, 4'h0);
      check("s wrap pulse", s_wrap, 1'b1);
      @(negedge clk);
      s_inc = 0;
      @(posedge clk); #1;
      check("s wrap clear", s_wrap, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
